// File: rtl/genaxis_axis_to_descriptor.sv
// Turns an AXIS packet into one descriptor {channel, status, length}. Status
// flags tid changes, bad tkeep, length overflow and data mismatches vs exp_data_i.

module genaxis_atd_lane #(
  parameter int W = 8
) (
  input  logic [W-1:0] data,
  input  logic [W-1:0] exp,
  input  logic         keep,
  output logic         mism
);
  assign mism = keep && (data != exp);
endmodule

module genaxis_axis_to_descriptor #(
  parameter int ID_WIDTH    = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int TKEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ID_WIDTH-1:0]     s_axis_tid_i,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata_i,
  input  logic                    s_axis_tvalid_i,
  input  logic                    s_axis_tlast_i,
  input  logic [TKEEP_WIDTH-1:0]  s_axis_tkeep_i,
  output logic                    s_axis_tready_o,
  input  logic [DATA_WIDTH-1:0]   exp_data_i,
  output logic                    exp_next_o,
  output logic [48+ID_WIDTH-1:0]  out_descriptor_data_o,
  output logic                    out_descriptor_valid_o,
  input  logic                    out_descriptor_ready_i
);
  typedef enum logic [1:0] {FIRST, BODY, REPORT} state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] ch;
  logic [16:0]         len_acc;   // bit 16 is a sticky overflow, low half saturates
  logic                ch_err, keep_err;
  logic [15:0]         mm_cnt;

  logic                   accept;
  logic [TKEEP_WIDTH-1:0] lane_mm;
  logic [TKEEP_WIDTH-1:0] keep_p1;
  logic [16:0]            pop, len_sum, len_nxt;
  logic                   ch_err_b, keep_err_b;
  logic [15:0]            mm_nxt;
  logic [ID_WIDTH-1:0]    ch_sel;
  logic [31:0]            status_nxt;

  assign s_axis_tready_o = (state != REPORT);
  assign accept          = s_axis_tvalid_i && s_axis_tready_o;
  assign exp_next_o      = accept;

  for (genvar g = 0; g < TKEEP_WIDTH; g++) begin : g_lane
    genaxis_atd_lane #(.W(8)) u_lane (
      .data (s_axis_tdata_i[g*8 +: 8]),
      .exp  (exp_data_i[g*8 +: 8]),
      .keep (s_axis_tkeep_i[g]),
      .mism (lane_mm[g])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < TKEEP_WIDTH; i++) pop = pop + 17'(s_axis_tkeep_i[i]);
  end

  assign len_sum = {1'b0, len_acc[15:0]} + pop;
  assign len_nxt = (len_acc[16] || len_sum[16]) ? 17'h1FFFF : len_sum;

  // A last beat's tkeep must be a non-empty run of ones starting at byte 0.
  assign keep_p1    = s_axis_tkeep_i + TKEEP_WIDTH'(1);
  assign keep_err_b = s_axis_tlast_i
                      ? ((s_axis_tkeep_i == '0) || ((s_axis_tkeep_i & keep_p1) != '0))
                      : !(&s_axis_tkeep_i);
  assign ch_err_b   = (state == BODY) && (s_axis_tid_i != ch);
  assign mm_nxt     = ((|lane_mm) && (mm_cnt != 16'hFFFF)) ? mm_cnt + 16'd1 : mm_cnt;
  assign ch_sel     = (state == FIRST) ? s_axis_tid_i : ch;
  assign status_nxt = {mm_nxt, 13'b0, len_nxt[16], keep_err | keep_err_b, ch_err | ch_err_b};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= FIRST;
      ch                     <= '0;
      len_acc                <= '0;
      ch_err                 <= 1'b0;
      keep_err               <= 1'b0;
      mm_cnt                 <= '0;
      out_descriptor_valid_o <= 1'b0;
      out_descriptor_data_o  <= '0;
    end else begin
      case (state)
        FIRST, BODY: begin
          if (accept) begin
            if (s_axis_tlast_i) begin
              out_descriptor_data_o  <= {ch_sel, status_nxt, len_nxt[15:0]};
              out_descriptor_valid_o <= 1'b1;
              state                  <= REPORT;
              ch                     <= '0;
              len_acc                <= '0;
              ch_err                 <= 1'b0;
              keep_err               <= 1'b0;
              mm_cnt                 <= '0;
            end else begin
              ch       <= ch_sel;
              len_acc  <= len_nxt;
              ch_err   <= ch_err | ch_err_b;
              keep_err <= keep_err | keep_err_b;
              mm_cnt   <= mm_nxt;
              state    <= BODY;
            end
          end
        end
        REPORT: begin
          if (out_descriptor_ready_i) begin
            out_descriptor_valid_o <= 1'b0;
            state                  <= FIRST;
          end
        end
        default: state <= FIRST;
      endcase
    end
  end
endmodule

// File: tb/tb_genaxis_axis_to_descriptor.sv
// Directed bench: inputs change on negedge, outputs checked on negedge.
module tb_genaxis_axis_to_descriptor;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  tid = '0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic [3:0]  tkeep = '0;
  logic        tready;
  logic [31:0] exp_data = '0;
  logic        exp_next;
  logic [57:0] desc;
  logic        desc_valid;
  logic        desc_ready = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int nxt_cnt = 0;
  int base;

  genaxis_axis_to_descriptor #(.ID_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .s_axis_tid_i           (tid),
    .s_axis_tdata_i         (tdata),
    .s_axis_tvalid_i        (tvalid),
    .s_axis_tlast_i         (tlast),
    .s_axis_tkeep_i         (tkeep),
    .s_axis_tready_o        (tready),
    .exp_data_i             (exp_data),
    .exp_next_o             (exp_next),
    .out_descriptor_data_o  (desc),
    .out_descriptor_valid_o (desc_valid),
    .out_descriptor_ready_i (desc_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (exp_next) nxt_cnt <= nxt_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic beat(input logic [9:0] id, input logic [31:0] d, input logic [31:0] e,
                      input logic [3:0] k, input logic l);
    @(negedge clk);
    tid = id; tdata = d; exp_data = e; tkeep = k; tlast = l; tvalid = 1'b1;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    tvalid = 1'b0;
    @(posedge clk);
  endtask

  // Called right after the last beat: descriptor must be valid at the next negedge.
  task automatic expect_desc(input string tag, input logic [57:0] d);
    @(negedge clk);
    tvalid = 1'b0;
    chk({tag, "_valid"}, 64'(desc_valid), 64'(1));
    chk({tag, "_data"}, 64'(desc), 64'(d));
    chk({tag, "_tready"}, 64'(tready), 64'(0));
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    desc_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    desc_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(desc_valid), 64'(0));
    chk({tag, "_tready_back"}, 64'(tready), 64'(1));
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_valid", 64'(desc_valid), 64'(0));
    chk("rst_data", 64'(desc), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tready", 64'(tready), 64'(1));
    chk("post_rst_exp_next", 64'(exp_next), 64'(0));

    // Clean 3-beat packet with idle gaps in between
    base = nxt_cnt;
    beat(10'd5, 32'h1234_5678, 32'h1234_5678, 4'hF, 1'b0);
    idle();
    idle();
    beat(10'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'hF, 1'b0);
    idle();
    beat(10'd5, 32'hAAAA_0102, 32'hAAAA_0102, 4'h3, 1'b1);
    expect_desc("clean", {10'd5, 32'h0, 16'd10});
    chk("clean_exp_next_cnt", 64'(nxt_cnt - base), 64'(3));
    handshake("clean");

    // Single beat
    beat(10'd3, 32'h0000_0042, 32'h0000_0042, 4'h1, 1'b1);
    expect_desc("single", {10'd3, 32'h0, 16'd1});
    handshake("single");

    // Mismatch in byte 1 of beat 2; last beat differs only in a masked byte
    beat(10'd7, 32'h0101_0101, 32'h0101_0101, 4'hF, 1'b0);
    beat(10'd7, 32'h0202_FF02, 32'h0202_0202, 4'hF, 1'b0);
    beat(10'd7, 32'h5503_0303, 32'h0303_0303, 4'h3, 1'b1);
    expect_desc("mismatch", {10'd7, 32'h0001_0000, 16'd10});
    handshake("mismatch");

    // tid change on beat 2, non-contiguous tkeep on last beat
    beat(10'd5, 32'h1, 32'h1, 4'hF, 1'b0);
    beat(10'd6, 32'h2, 32'h2, 4'hF, 1'b0);
    beat(10'd5, 32'h3, 32'h3, 4'h5, 1'b1);
    expect_desc("proto", {10'd5, 32'h0000_0003, 16'd10});
    handshake("proto");

    // Backpressure: a pending beat must not be taken while the result waits
    beat(10'd9, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'hF, 1'b1);
    expect_desc("bp", {10'd9, 32'h0, 16'd4});
    tid = 10'd2; tdata = 32'hFFFF_FFFF; exp_data = 32'h0; tkeep = 4'hF; tlast = 1'b1; tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(desc_valid), 64'(1));
      chk("bp_hold_data", 64'(desc), 64'({10'd9, 32'h0, 16'd4}));
      chk("bp_hold_tready", 64'(tready), 64'(0));
      chk("bp_hold_exp_next", 64'(exp_next), 64'(0));
    end
    tvalid = 1'b0;
    handshake("bp");
    beat(10'd2, 32'h0000_1111, 32'h0000_1111, 4'h3, 1'b1);
    expect_desc("after_bp", {10'd2, 32'h0, 16'd2});
    handshake("after_bp");

    // Long packet overflows the length field
    for (int i = 0; i < 16400; i++)
      beat(10'd1, 32'(i), 32'(i), 4'hF, i == 16399);
    expect_desc("long", {10'd1, 32'h0000_0004, 16'hFFFF});
    handshake("long");

    // Reset mid-packet discards it; next clean packet starts fresh
    beat(10'd4, 32'h1, 32'h2, 4'hF, 1'b0);
    beat(10'd8, 32'h3, 32'h3, 4'h1, 1'b0);
    @(negedge clk);
    tvalid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(desc_valid), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_desc", 64'(desc_valid), 64'(0));
    end
    beat(10'd11, 32'hABCD_0000, 32'hABCD_0000, 4'hF, 1'b0);
    beat(10'd11, 32'h0000_ABCD, 32'h0000_ABCD, 4'hF, 1'b1);
    expect_desc("after_rst", {10'd11, 32'h0, 16'd8});
    handshake("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/genaxis_axis_to_descriptor.md
GENAXIS_AXIS_TO_DESCRIPTOR -- requirements
Module: genaxis_axis_to_descriptor

Interface
REQ-001 Parameter ID_WIDTH, default 10, width of the AXIS channel id.
REQ-002 Parameter DATA_WIDTH, default 32, AXIS data width in bits; multiple of 8.
REQ-003 Parameter TKEEP_WIDTH, default DATA_WIDTH/8, AXIS byte-enable width.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 s_axis_tid_i  input  ID_WIDTH  incoming channel id.
REQ-007 s_axis_tdata_i  input  DATA_WIDTH  incoming data.
REQ-008 s_axis_tvalid_i  input  1  beat valid.
REQ-009 s_axis_tlast_i  input  1  last beat of packet.
REQ-010 s_axis_tkeep_i  input  TKEEP_WIDTH  byte enables.
REQ-011 s_axis_tready_o  output  1  beat accepted when tvalid and tready are both high.
REQ-012 exp_data_i  input  DATA_WIDTH  expected pseudo-random data for the current beat.
REQ-013 exp_next_o  output  1  one-cycle pulse that advances the external expected-data generator.
REQ-014 out_descriptor_data_o  output  48+ID_WIDTH  result {channel, status[31:0], length[15:0]}.
REQ-015 out_descriptor_valid_o  output  1  result valid.
REQ-016 out_descriptor_ready_i  input  1  result consumer ready.

Function
REQ-017 The FSM SHALL have states FIRST (waiting for the first beat), BODY (inside a packet) and REPORT (result pending).
REQ-018 s_axis_tready_o SHALL be 1 in FIRST and BODY and 0 in REPORT, decoded combinationally from state.
REQ-019 exp_next_o SHALL equal s_axis_tvalid_i & s_axis_tready_o in the same cycle.
REQ-020 A beat accepted in FIRST SHALL latch s_axis_tid_i as the packet channel.
REQ-021 A beat accepted in FIRST with tlast=0 SHALL move the FSM to BODY.
REQ-022 A beat accepted in BODY whose tid differs from the latched channel SHALL set status bit 0; the channel SHALL stay at its first-beat value.
REQ-023 Each accepted beat SHALL add popcount(tkeep) to a 17-bit accumulator; length SHALL saturate at 16'hFFFF, and status bit 2 SHALL be set once the true sum exceeds 65535.
REQ-024 A non-last beat with tkeep != all-ones, or a last beat whose tkeep is zero or not contiguous from the LSB, SHALL set status bit 1.
REQ-025 Each accepted beat where any byte with tkeep=1 differs from exp_data_i SHALL increment status[31:16]; the count SHALL saturate at 16'hFFFF, and bytes with tkeep=0 SHALL be ignored.
REQ-026 status[15:3] SHALL always be 0.
REQ-027 A beat accepted with tlast=1, from FIRST or BODY, SHALL register the descriptor and assert out_descriptor_valid_o on the next cycle, entering REPORT.
REQ-028 On that same edge the length, status and channel accumulators SHALL be cleared.
REQ-029 The final beat's contribution SHALL be included in the reported length and status.
REQ-030 In REPORT, out_descriptor_data_o and out_descriptor_valid_o SHALL hold stable until out_descriptor_ready_i=1.
REQ-031 On the REPORT handshake cycle, valid SHALL drop on the next edge and the FSM SHALL return to FIRST; there SHALL be exactly one bubble cycle between packets.
REQ-032 s_axis_tvalid_i=0 in any state SHALL leave all accumulators unchanged.

Reset
REQ-033 Asserting reset_n=0 SHALL asynchronously force state=FIRST, out_descriptor_valid_o=0, out_descriptor_data_o=0, and clear the length, status and channel accumulators.
REQ-034 After reset release, s_axis_tready_o SHALL be 1, and exp_next_o SHALL be 0 while s_axis_tvalid_i=0.
REQ-035 Reset asserted mid-packet SHALL discard the partial packet; no descriptor SHALL be emitted for it.

Verification (DATA_WIDTH=32, ID_WIDTH=10)
REQ-036 Clean packet: tid=5, 3 beats, tkeep 1111/1111/0011, data = exp -> one descriptor {5, 32'h0, 16'd10}; exp_next_o pulses 3 times.
REQ-037 Single beat: tkeep=0001, tlast=1, data matches -> descriptor {ch, 32'h0, 16'd1}; valid asserts the cycle after the beat.
REQ-038 Mismatch: beat 2 of 3 differs in byte 1 (tkeep=1111), plus a last beat differing only in a byte with tkeep=0 -> status = 32'h0001_0000.
REQ-039 Protocol errors: tid 5->6 on beat 2 and last tkeep=0101 -> channel=5, status bits 0 and 1 set.
REQ-040 Backpressure: out_descriptor_ready_i held 0 for 10 cycles -> tready=0 and descriptor stable throughout; the next packet is accepted starting one cycle after the handshake.
REQ-041 Long packet: 16400 full beats (65600 bytes) -> length=16'hFFFF, status bit 2 set; reset asserted mid-packet, then a clean 2-beat packet -> only the clean packet's descriptor, {ch, 0, 8}.
